// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory request/response channel and decode-side handshake
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: credit-limited fetch with a {pc, word} buffer; IFETCH_MISALIGN_CHECK_EN adds misaligned_fault
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
`ifdef IFETCH_MISALIGN_CHECK_EN
    output logic                misaligned_fault,
`endif
    instruction_fetch_if.master bus
);
    localparam int            AW    = $clog2(FIFO_DEPTH);
    localparam int            CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc, rsp_pc, target_pc;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_word [FIFO_DEPTH];
    logic [CW-1:0] outstanding, drop_cnt, count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          blocked, req_fire, push, pop;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic fault;
    assign blocked          = fault;
    assign misaligned_fault = fault;
    // keep the raw target in fetch_pc so a faulting address stays visible
    assign target_pc        = redirect_pc;
    always_ff @(posedge clk) begin
        if (reset)
            fault <= 1'b0;
        else if (redirect_valid)
            fault <= redirect_pc[1:0] != 2'b00;
    end
`else
    assign blocked   = 1'b0;
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

    // outstanding + buffered never exceeds the buffer, so a push always has room
    assign bus.imem_req_valid = !reset && !redirect_valid && !blocked &&
                                ({1'b0, outstanding} + {1'b0, count} < DEPTH);
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = (count != '0) && !redirect_valid && !reset;
    assign bus.instr          = fifo_word[rd_ptr];
    assign bus.instr_pc       = fifo_pc[rd_ptr];
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign pop                = bus.instr_valid && bus.instr_ready;
    assign push               = bus.imem_rsp_valid && (drop_cnt == '0) && !redirect_valid && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= target_pc;
            rsp_pc      <= target_pc & 32'hFFFF_FFFC;
            drop_cnt    <= outstanding - CW'(bus.imem_rsp_valid);
            outstanding <= outstanding - CW'(bus.imem_rsp_valid);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (bus.imem_rsp_valid && drop_cnt != '0)
                drop_cnt <= drop_cnt - CW'(1);
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            count       <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_word[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vectors against a fixed-latency memory model and a decode-side log
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        misaligned_fault;
    logic        s_fault;
`endif

    instruction_fetch_if bus();

    instruction_fetch dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
`ifdef IFETCH_MISALIGN_CHECK_EN
        .misaligned_fault(misaligned_fault),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic ir; logic rv; logic [31:0] ra; logic iv; logic [31:0] pc; } vec_t;

    req_t        pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_w[$];
    vec_t        tbl[22];
    int          cyc = 0, lat = 1, errors = 0, checks = 0;
    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // drive response at negedge, sample just after, record handshakes, return after next posedge
    task automatic tick();
        req_t r;
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memf(r.addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        s_rv    = bus.imem_req_valid;
        s_addr  = bus.imem_req_addr;
        s_iv    = bus.instr_valid;
        s_pc    = bus.instr_pc;
        s_instr = bus.instr;
`ifdef IFETCH_MISALIGN_CHECK_EN
        s_fault = misaligned_fault;
`endif
        if (!reset && bus.imem_req_valid && bus.imem_req_ready)
            pend.push_back('{bus.imem_req_addr, cyc + lat});
        if (bus.instr_valid && bus.instr_ready) begin
            got_pc.push_back(bus.instr_pc);
            got_w.push_back(bus.instr);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pend.delete();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (2) begin
            tick();
            chk("reset_req_valid", 32'(s_rv), 32'd0);
            chk("reset_instr_valid", 32'(s_iv), 32'd0);
`ifdef IFETCH_MISALIGN_CHECK_EN
            chk("reset_fault", 32'(s_fault), 32'd0);
`endif
        end
        reset = 1'b0;
        got_pc.delete();
        got_w.delete();
    endtask

    task automatic chk_log(input string name, input int n, input logic [31:0] base);
        chk({name, "_count"}, 32'(got_pc.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i < got_pc.size()) begin
                chk({name, "_pc"}, got_pc[i], base + 32'(4 * i));
                chk({name, "_word"}, got_w[i], memf(base + 32'(4 * i)));
            end
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        tick();
        chk("redirect_req_valid", 32'(s_rv), 32'd0);
        chk("redirect_instr_valid", 32'(s_iv), 32'd0);
        redirect_valid = 1'b0;
    endtask

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        tbl[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        tbl[7]  = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
        for (int i = 8; i < 18; i++)
            tbl[i] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[18] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[19] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
        tbl[20] = '{1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        tbl[21] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h18};

        do_reset();
        foreach (tbl[i]) begin
            bus.instr_ready = tbl[i].ir;
            tick();
            chk($sformatf("vec%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].rv));
            if (tbl[i].rv)
                chk($sformatf("vec%0d_req_addr", i), s_addr, tbl[i].ra);
            chk($sformatf("vec%0d_instr_valid", i), 32'(s_iv), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk($sformatf("vec%0d_instr_pc", i), s_pc, tbl[i].pc);
                chk($sformatf("vec%0d_instr", i), s_instr, memf(tbl[i].pc));
            end
        end
        chk_log("stream", 7, 32'h0);

        lat = 3;
        do_reset();
        tick();
        tick();
        redirect_to(32'h100);
        got_pc.delete();
        got_w.delete();
        repeat (30) tick();
        chk_log("redir_inflight", 3, 32'h100);
        redirect_to(32'h300);
        redirect_to(32'h400);
        got_pc.delete();
        got_w.delete();
        repeat (30) tick();
        chk_log("redir_b2b", 3, 32'h400);

        lat = 1;
        do_reset();
        tick();
        tick();
        redirect_to(32'h200);
        chk("no_xfer_on_redirect", 32'(got_pc.size()), 32'd0);
        tick();
        chk("post_redir_req_valid", 32'(s_rv), 32'd1);
        chk("post_redir_req_addr", s_addr, 32'h200);
        chk("post_redir_flushed", 32'(s_iv), 32'd0);
        repeat (10) tick();
        chk_log("redir_same_cycle", 3, 32'h200);

        do_reset();
        repeat (3) tick();
        bus.imem_req_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_req_valid", 32'(s_rv), 32'd1);
            chk("stall_req_addr", s_addr, 32'h8);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        chk("stall_accept_addr", s_addr, 32'h8);
        tick();
        chk("stall_next_addr", s_addr, 32'hC);
        repeat (10) tick();
        chk_log("stall", 5, 32'h0);

`ifdef IFETCH_MISALIGN_CHECK_EN
        do_reset();
        tick();
        tick();
        redirect_to(32'h102);
        repeat (5) begin
            tick();
            chk("fault_set", 32'(s_fault), 32'd1);
            chk("fault_blocks_req", 32'(s_rv), 32'd0);
        end
        redirect_to(32'h200);
        got_pc.delete();
        got_w.delete();
        tick();
        chk("fault_cleared", 32'(s_fault), 32'd0);
        chk("fault_resume_valid", 32'(s_rv), 32'd1);
        chk("fault_resume_addr", s_addr, 32'h200);
        repeat (10) tick();
        chk_log("after_fault", 3, 32'h200);
`else
        do_reset();
        tick();
        tick();
        redirect_to(32'h305);
        got_pc.delete();
        got_w.delete();
        tick();
        chk("mask_req_valid", 32'(s_rv), 32'd1);
        chk("mask_req_addr", s_addr, 32'h304);
        repeat (10) tick();
        chk_log("mask_low_bits", 3, 32'h304);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
